// File: rtl/laser_ram_arbiter_pkg.sv
// laser_ram_pkg: shared state encoding and decode constants for the Laser 310 SRAM arbiter
package laser_ram_pkg;
  typedef enum logic [2:0] {S_IDLE, S_Z80, S_LD_SETUP, S_LD_STROBE, S_LD_HOLD} state_t;
  localparam logic [3:0] IO_BANK_PORT = 4'b0111;
  localparam logic [4:0] WIN_LO = 5'b10111;
  localparam logic [4:0] WIN_HI = 5'b11111;
  localparam logic [1:0] BANK_RESET = 2'b01;
  // Offset compare wraps below WIN_LO, so one unsigned test covers both bounds
  function automatic logic in_window(input logic [4:0] a_hi);
    return 5'(a_hi - WIN_LO) <= 5'(WIN_HI - WIN_LO);
  endfunction
endpackage

// File: rtl/laser_ram_arbiter_if.sv
// laser_ram_arbiter_if: Z80, loader and SRAM signals shared by the arbiter and its environment
interface laser_ram_arbiter_if;
  logic [15:0] z80_a;
  logic [3:0]  z80_aio;
  logic [1:0]  z80_d10;
  logic        z80_mreq_n, z80_iorq_n, z80_rd_n, z80_wr_n;
  logic        ld_req, ld_we, ld_ack;
  logic [15:0] ld_addr;
  logic [7:0]  ld_wdata, ld_rdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout, ram_din;
  logic        ram_dq_oe, ram_cs_n, ram_oe_n, ram_we_n;
  logic [1:0]  bank;
  logic        led1, led2;
  modport slave (
    input  z80_a, z80_aio, z80_d10, z80_mreq_n, z80_iorq_n, z80_rd_n, z80_wr_n,
    input  ld_req, ld_we, ld_addr, ld_wdata, ram_din,
    output ld_ack, ld_rdata, ram_addr, ram_dout, ram_dq_oe, ram_cs_n, ram_oe_n, ram_we_n,
    output bank, led1, led2
  );
  modport master (
    output z80_a, z80_aio, z80_d10, z80_mreq_n, z80_iorq_n, z80_rd_n, z80_wr_n,
    output ld_req, ld_we, ld_addr, ld_wdata, ram_din,
    input  ld_ack, ld_rdata, ram_addr, ram_dout, ram_dq_oe, ram_cs_n, ram_oe_n, ram_we_n,
    input  bank, led1, led2
  );
endinterface

// File: rtl/laser_ram_arbiter_sync.sv
// laser_bus_sync: multi-stage synchronizer for the asynchronous Z80 strobes and I/O address bits
module laser_bus_sync #(
  parameter int W = 8,
  parameter int STAGES = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [STAGES-1:0][W-1:0] r_ff;
  always_ff @(posedge clk)
    if (!rst_n) r_ff <= {STAGES{RST_VAL}};
    else r_ff <= {r_ff[STAGES-2:0], i_d};
  assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/laser_ram_arbiter.sv
// laser_ram_arbiter: shares the cartridge SRAM between the Z80 window B800h-FFFFh and a loader port
module laser_ram_arbiter
  import laser_ram_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LD_STROBE_CYC = 2
) (
  input logic clk,
  input logic rst_n,
  laser_ram_arbiter_if.slave bus
);
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_bank;
  logic [15:0] r_addr;
  logic [7:0]  r_dout, r_rdata;
  logic        r_ack, r_cs_n, r_oe_n, r_we_n, r_dq_oe, r_led1, r_led2, r_iowr_d;
  logic        w_mreq_n, w_iorq_n, w_rd_n, w_wr_n, w_iowr, w_zrd, w_zwr, w_zreq;
  logic [3:0]  w_aio;
  logic [15:0] w_zaddr;
  laser_bus_sync #(.W(8), .STAGES(SYNC_STAGES), .RST_VAL(8'hF0)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  ({bus.z80_mreq_n, bus.z80_iorq_n, bus.z80_rd_n, bus.z80_wr_n, bus.z80_aio}),
    .o_q  ({w_mreq_n, w_iorq_n, w_rd_n, w_wr_n, w_aio})
  );
  assign w_iowr  = !w_iorq_n && !w_wr_n && w_aio == IO_BANK_PORT;
  assign w_zrd   = !w_mreq_n && !w_rd_n && w_wr_n;
  assign w_zwr   = !w_mreq_n && w_rd_n && !w_wr_n;
  assign w_zreq  = (w_zrd || w_zwr) && in_window(bus.z80_a[15:11]);
  // B800h-BFFFh is pinned to bank 0; the rest of the window follows the bank register
  assign w_zaddr = {bus.z80_a[15:11] == WIN_LO ? 2'b00 : r_bank, bus.z80_a[13:0]};
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bank   <= BANK_RESET;
      r_addr   <= '0;
      r_dout   <= '0;
      r_rdata  <= '0;
      r_ack    <= 1'b0;
      r_cs_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_dq_oe  <= 1'b0;
      r_led1   <= 1'b0;
      r_led2   <= 1'b0;
      r_iowr_d <= 1'b0;
    end else begin
      r_iowr_d <= w_iowr;
      if (w_iowr && !r_iowr_d) r_bank <= bus.z80_d10 == 2'b00 ? BANK_RESET : bus.z80_d10;
      r_dout <= bus.ld_wdata;
      r_led1 <= !r_cs_n;
      r_led2 <= !r_we_n;
      r_ack  <= 1'b0;
      case (r_state)
        S_IDLE, S_Z80:
          if (w_zreq) begin
            r_state <= S_Z80;
            r_addr  <= w_zaddr;
            r_cs_n  <= 1'b0;
            r_oe_n  <= !w_zrd;
            r_we_n  <= !w_zwr;
            r_dq_oe <= 1'b0;
          end else if (bus.ld_req && r_state == S_IDLE) begin
            r_state <= S_LD_SETUP;
            r_addr  <= bus.ld_addr;
            r_cs_n  <= 1'b0;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_dq_oe <= bus.ld_we;
          end else begin
            r_state <= S_IDLE;
            r_cs_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
          end
        S_LD_SETUP: begin
          r_state <= S_LD_STROBE;
          r_cnt   <= '0;
          r_oe_n  <= bus.ld_we;
          r_we_n  <= !bus.ld_we;
        end
        S_LD_STROBE:
          if (r_cnt == 8'(LD_STROBE_CYC - 1)) begin
            r_state <= S_LD_HOLD;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ack   <= 1'b1;
            if (!bus.ld_we) r_rdata <= bus.ram_din;
          end else r_cnt <= r_cnt + 8'd1;
        S_LD_HOLD: begin
          r_state <= S_IDLE;
          r_cs_n  <= 1'b1;
          r_dq_oe <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign bus.ram_addr  = r_addr;
  assign bus.ram_dout  = r_dout;
  assign bus.ram_cs_n  = r_cs_n;
  assign bus.ram_oe_n  = r_oe_n;
  assign bus.ram_we_n  = r_we_n;
  assign bus.ram_dq_oe = r_dq_oe;
  assign bus.ld_ack    = r_ack;
  assign bus.ld_rdata  = r_rdata;
  assign bus.bank      = r_bank;
  assign bus.led1      = r_led1;
  assign bus.led2      = r_led2;
endmodule
